// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush controller for a 5-stage pipeline. It decides every cycle
//   whether the pipeline advances, freezes on a memory wait, squashes
//   wrong-path instructions after a taken branch, or inserts a load-use
//   bubble. A halt in WB parks the pipeline until reset.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   ihit, dhit        instruction / data memory ready
//   mem_req           MEM stage has a data access pending
//   idex_dREN/rt      load in ID/EX and its destination register
//   ifid_rs/rt        source registers of the IF/ID instruction
//   ex_pcsrc          taken branch/jump resolved in EX
//   wb_halt           halt instruction reached WB
//   pc_en, *_en       PC and pipeline register write enables
//   *_flush           pipeline register clear-to-bubble (wins over *_en)
//   halted            processor is parked in HALT
//   stall_cnt         saturating count of cycles with pc_en=0 (not in HALT)
//   flush_cnt         saturating count of taken-branch flush cycles
module pipeline_hazard_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_req,
  input  logic        idex_dREN,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ex_pcsrc,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, FREEZE, HALT} state_t;

  state_t state, next_state;
  logic   freeze_cond, lu_hazard, flush_evt;

  // Memory wait: a pending data access waits on dhit; otherwise the fetch
  // waits on ihit.
  assign freeze_cond = (mem_req && !dhit) || (!mem_req && !ihit);

  // r0 is hardwired zero, so a load into it never creates a dependency.
  assign lu_hazard = idex_dREN && (idex_rt != 5'd0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN, FREEZE: begin
        if (wb_halt)          next_state = HALT;
        else if (freeze_cond) next_state = FREEZE;
        else                  next_state = RUN;
      end
      HALT:    next_state = HALT;
      default: next_state = RUN;
    endcase
  end

  // Outputs depend on the current inputs, so the cycle that ends a freeze
  // already applies the branch/load-use/normal controls. A branch seen while
  // frozen stays in EX (its register is held) and is flushed on release.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    flush_evt   = 1'b0;
    if (RST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
    end else if (state == HALT || freeze_cond) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
    end else if (ex_pcsrc) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_evt  = 1'b1;
    end else if (lu_hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign halted = (state == HALT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && state != HALT && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (flush_evt && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by random traffic, all compared against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, mem_req, idex_dREN, ex_pcsrc, wb_halt;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit m_halted;
  int m_stall, m_flush;

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs),
    .ifid_rt(ifid_rt), .ex_pcsrc(ex_pcsrc), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Expected controls packed as {pc,ifid,idex,exmem,memwb en | ifid,idex,exmem flush}.
  function automatic logic [7:0] expect_ctl();
    bit wait_mem, hazard;
    wait_mem = mem_req ? !dhit : !ihit;
    hazard   = idex_dREN && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    if (RST)           return 8'b00000_111;
    if (m_halted)      return 8'b00000_000;
    if (wait_mem)      return 8'b00000_000;
    if (ex_pcsrc)      return 8'b11111_110;
    if (hazard)        return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  // Check one cycle's outputs (inputs already driven), clock it, advance the model.
  task automatic cycle();
    logic [7:0] e;
    #1;
    e = expect_ctl();
    check("ctl", int'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush}), int'(e));
    check("halted", int'(halted), int'(m_halted));
    check("stall_cnt", int'(stall_cnt), m_stall);
    check("flush_cnt", int'(flush_cnt), m_flush);
    @(posedge CLK);
    if (RST) begin
      m_halted = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halted) begin
      if (!e[7])          m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (e == 8'b11111_110) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      if (wb_halt)        m_halted = 1;
    end
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    RST = 0; ihit = 1; dhit = 0; mem_req = 0; idex_dREN = 0; ex_pcsrc = 0;
    wb_halt = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); RST = 1; cycle(); RST = 0;
  endtask

  initial begin
    m_halted = 0; m_stall = 0; m_flush = 0;
    idle_inputs();
    RST = 1;
    @(negedge CLK);
    // first reset edge: model starts from reset values
    @(posedge CLK); @(negedge CLK);
    cycle();                       // RST still high: forced flush outputs
    RST = 0;
    check("rst_stall", int'(stall_cnt), 0);
    check("rst_halted", int'(halted), 0);

    // load-use hazard: one bubble, stall_cnt 0->1
    idex_dREN = 1; idex_rt = 5; ifid_rs = 5; cycle();
    check("lu_stall", int'(stall_cnt), 1);
    idex_dREN = 0; cycle();
    // zero register never hazards
    idex_dREN = 1; idex_rt = 0; ifid_rs = 0; ifid_rt = 0; cycle();
    check("r0_stall", int'(stall_cnt), 1);
    idex_dREN = 1; idex_rt = 7; ifid_rs = 3; ifid_rt = 7; cycle();
    idle_inputs();

    // memory wait of 3 cycles then release
    do_reset();
    mem_req = 1; dhit = 0;
    repeat (3) cycle();
    check("memwait_stall", int'(stall_cnt), 3);
    dhit = 1; #1;
    check("release_pc_en", int'(pc_en), 1);
    cycle();
    idle_inputs();

    // taken branch held through a 2-cycle freeze
    do_reset();
    mem_req = 1; dhit = 0; ex_pcsrc = 1;
    repeat (2) cycle();
    check("frozen_noflush", int'(flush_cnt), 0);
    dhit = 1; #1;
    check("release_flush", int'({ifid_flush, idex_flush}), 3);
    cycle();
    ex_pcsrc = 0; mem_req = 0; cycle();
    check("branch_flush_cnt", int'(flush_cnt), 1);

    // halt during a memory wait, sticky until reset
    wb_halt = 1; mem_req = 1; dhit = 0; cycle();
    wb_halt = 0; check("halted_set", int'(halted), 1);
    mem_req = 0; ex_pcsrc = 1; repeat (3) cycle();
    ex_pcsrc = 0;
    do_reset();
    check("halt_cleared", int'(halted), 0);

    // stall counter saturation
    ihit = 0;
    repeat (65537) cycle();
    check("stall_sat", int'(stall_cnt), 16'hFFFF);
    ihit = 1; idex_dREN = 1; idex_rt = 9; ifid_rt = 9; cycle(); cycle();
    check("stall_held", int'(stall_cnt), 16'hFFFF);
    do_reset();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      RST       = (m_halted && $urandom_range(7) == 0) || $urandom_range(79) == 0;
      wb_halt   = $urandom_range(39) == 0;
      ihit      = $urandom_range(4) != 0;
      mem_req   = $urandom_range(2) == 0;
      dhit      = $urandom_range(2) != 0;
      idex_dREN = $urandom_range(1) == 1;
      idex_rt   = 5'($urandom_range(3));
      ifid_rs   = 5'($urandom_range(3));
      ifid_rt   = 5'($urandom_range(3));
      ex_pcsrc  = $urandom_range(4) == 0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
